// File: rtl/msk_unmask_pkg.sv
// msk_unmask_pkg: shared state encoding and counter sizing for the serial unmasker.
package msk_unmask_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic int cnt_width(input int d);
        return $clog2(d + 1);
    endfunction
endpackage

// File: rtl/msk_share_mux.sv
// msk_share_mux: picks share[sel] out of the d shares of one bit.
module msk_share_mux #(
    parameter int d  = 2,
    parameter int CW = 2
) (
    input  logic [d-1:0]  slot,
    input  logic [CW-1:0] sel,
    output logic          share
);
    always_comb begin
        share = 1'b0;
        for (int j = 0; j < d; j++) if (sel == CW'(j)) share = slot[j];
    end
endmodule

// File: rtl/msk_unmask_serial.sv
// msk_unmask_serial: recombines a d-share boolean masking one share per cycle,
// so no two input shares ever meet in the same combinational XOR.
module msk_unmask_serial
    import msk_unmask_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W*d-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready
);
    localparam int CW = cnt_width(d);

    if (d < 2) begin : g_bad_d
        $error("msk_unmask_serial: d must be at least 2");
    end

    state_t state, state_next;
    logic [W*d-1:0] share_q, keep;
    logic [W-1:0] acc, pick, share0;
    logic [CW-1:0] cnt;
    logic last;

    assign last      = cnt == CW'(d - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_data  = out_valid ? acc : '0;

    for (genvar b = 0; b < W; b++) begin : g_bit
        assign share0[b] = in_data[b*d];
        msk_share_mux #(.d(d), .CW(CW)) u_mux (
            .slot (share_q[b*d +: d]),
            .sel  (cnt),
            .share(pick[b])
        );
    end

    // Slot 0 went straight into acc on accept; scrub it alongside the consumed slot.
    always_comb begin
        keep = '1;
        for (int i = 0; i < W; i++) begin
            keep[i*d] = 1'b0;
            for (int j = 1; j < d; j++) if (cnt == CW'(j)) keep[i*d+j] = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        if (state == IDLE && in_valid) state_next = ACCUM;
        else if (state == ACCUM && last) state_next = DONE;
        else if (state == DONE && out_ready) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share_q <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    share_q <= in_data;
                    acc     <= share0;
                    cnt     <= CW'(1);
                end
                ACCUM: begin
                    acc     <= acc ^ pick;
                    share_q <= share_q & keep;
                    cnt     <= last ? '0 : cnt + CW'(1);
                end
                DONE: if (out_ready) begin
                    share_q <= '0;
                    acc     <= '0;
                    cnt     <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_msk_unmask_serial.sv
// tb_msk_unmask_serial: checks four parameterisations of the unmasker against a
// share-XOR reference model with directed and random sharings.
module tb_msk_unmask_serial;
    logic clk = 1'b0;
    logic rst_n;
    logic [39:0] in_data_a [4];
    logic in_valid_a [4];
    logic out_ready_a [4];
    logic in_ready_a [4];
    logic out_valid_a [4];
    logic [7:0] out_data_a [4];
    logic [3:0] od3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign out_data_a[1] = {4'h0, od3};

    msk_unmask_serial #(.d(2), .W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[0][15:0]), .in_valid(in_valid_a[0]),
        .in_ready(in_ready_a[0]), .out_data(out_data_a[0]), .out_valid(out_valid_a[0]),
        .out_ready(out_ready_a[0]));
    msk_unmask_serial #(.d(3), .W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[1][11:0]), .in_valid(in_valid_a[1]),
        .in_ready(in_ready_a[1]), .out_data(od3), .out_valid(out_valid_a[1]),
        .out_ready(out_ready_a[1]));
    msk_unmask_serial #(.d(4), .W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[2][31:0]), .in_valid(in_valid_a[2]),
        .in_ready(in_ready_a[2]), .out_data(out_data_a[2]), .out_valid(out_valid_a[2]),
        .out_ready(out_ready_a[2]));
    msk_unmask_serial #(.d(5), .W(8)) u5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[3]), .in_valid(in_valid_a[3]),
        .in_ready(in_ready_a[3]), .out_data(out_data_a[3]), .out_valid(out_valid_a[3]),
        .out_ready(out_ready_a[3]));

    function automatic logic [39:0] pack(input int dd, input int ww, input logic [7:0] sh [5]);
        logic [39:0] r = '0;
        for (int i = 0; i < ww; i++)
            for (int j = 0; j < dd; j++) r[i*dd+j] = sh[j][i];
        return r;
    endfunction

    function automatic logic [7:0] model(input int dd, input int ww, input logic [7:0] sh [5]);
        logic [7:0] x = '0;
        for (int j = 0; j < dd; j++) x ^= sh[j];
        return x & 8'((1 << ww) - 1);
    endfunction

    // Entered and left on a falling edge; one full transaction with junk inputs while busy.
    task automatic run_one(input int k, input int dd, input int ww, input logic [7:0] sh [5],
                           input int hold, input string name);
        logic [7:0] exp;
        exp = model(dd, ww, sh);
        in_data_a[k] = pack(dd, ww, sh);
        in_valid_a[k] = 1'b1;
        out_ready_a[k] = 1'($urandom);
        checks++;
        if (in_ready_a[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: in_ready=%b expected 1", name, in_ready_a[k]);
        end
        @(posedge clk);
        @(negedge clk);
        for (int n = 0; n < dd - 1; n++) begin
            checks++;
            if (out_valid_a[k] !== 1'b0 || in_ready_a[k] !== 1'b0 || out_data_a[k] !== 8'h00) begin
                errors++;
                $display("FAIL %s accum%0d: out_valid=%b in_ready=%b out_data=%h expected 0 0 00",
                         name, n, out_valid_a[k], in_ready_a[k], out_data_a[k]);
            end
            in_valid_a[k] = 1'($urandom);
            in_data_a[k] = 40'({$urandom, $urandom});
            out_ready_a[k] = 1'($urandom);
            @(negedge clk);
        end
        checks++;
        if (out_valid_a[k] !== 1'b1 || out_data_a[k] !== exp) begin
            errors++;
            $display("FAIL %s done: out_valid=%b out_data=%h expected 1 %h",
                     name, out_valid_a[k], out_data_a[k], exp);
        end
        if (k == 1) begin
            checks++;
            if (u3.share_q !== 12'h000) begin
                errors++;
                $display("FAIL %s share_clear: share_q=%h expected 000", name, u3.share_q);
            end
        end
        for (int h = 0; h < hold; h++) begin
            out_ready_a[k] = 1'b0;
            in_valid_a[k] = 1'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid_a[k] !== 1'b1 || out_data_a[k] !== exp) begin
                errors++;
                $display("FAIL %s hold%0d: out_valid=%b out_data=%h expected 1 %h",
                         name, h, out_valid_a[k], out_data_a[k], exp);
            end
        end
        out_ready_a[k] = 1'b1;
        @(negedge clk);
        in_valid_a[k] = 1'b0;
        out_ready_a[k] = 1'b0;
        checks++;
        if (in_ready_a[k] !== 1'b1 || out_valid_a[k] !== 1'b0 || out_data_a[k] !== 8'h00) begin
            errors++;
            $display("FAIL %s release: in_ready=%b out_valid=%b out_data=%h expected 1 0 00",
                     name, in_ready_a[k], out_valid_a[k], out_data_a[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data_a[k] = '0;
            in_valid_a[k] = 1'b0;
            out_ready_a[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_ready_a[k] !== 1'b1 || out_valid_a[k] !== 1'b0 || out_data_a[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset%0d: in_ready=%b out_valid=%b out_data=%h expected 1 0 00",
                         k, in_ready_a[k], out_valid_a[k], out_data_a[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_known();
        logic [7:0] sh [5];
        sh = '{8'h99, 8'h3C, 8'h00, 8'h00, 8'h00};
        run_one(0, 2, 8, sh, 0, "a5");
        sh = '{8'h09, 8'h06, 8'h0F, 8'h00, 8'h00};
        run_one(1, 3, 4, sh, 1, "zero");
    endtask

    task automatic test_hold();
        logic [7:0] sh [5];
        sh = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
        run_one(0, 2, 8, sh, 5, "hold");
        sh = '{8'hF0, 8'h0F, 8'h00, 8'h00, 8'h00};
        run_one(0, 2, 8, sh, 0, "after_hold");
    endtask

    task automatic test_reset_mid();
        logic [7:0] sh [5];
        sh = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h00};
        in_data_a[2] = pack(4, 8, sh);
        in_valid_a[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[2] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready_a[2] !== 1'b1 || out_valid_a[2] !== 1'b0 || out_data_a[2] !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b out_data=%h expected 1 0 00",
                     in_ready_a[2], out_valid_a[2], out_data_a[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sh = '{8'hC3, 8'h5E, 8'h21, 8'hE6, 8'h00};
        run_one(2, 4, 8, sh, 1, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] sh [3][5];
        logic [7:0] outs [$];
        int acc_cyc [$];
        int idx = 0;
        for (int t = 0; t < 3; t++)
            for (int j = 0; j < 5; j++) sh[t][j] = 8'($urandom);
        out_ready_a[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (out_valid_a[0] === 1'b1) outs.push_back(out_data_a[0]);
            in_valid_a[0] = idx < 3;
            if (idx < 3) begin
                in_data_a[0] = pack(2, 8, sh[idx]);
                if (in_ready_a[0] === 1'b1) begin
                    acc_cyc.push_back(c);
                    idx++;
                end
            end
            @(negedge clk);
        end
        in_valid_a[0] = 1'b0;
        out_ready_a[0] = 1'b0;
        checks++;
        if (acc_cyc.size() != 3 || outs.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d outputs=%0d expected 3 3", acc_cyc.size(), outs.size());
        end else begin
            for (int t = 0; t < 3; t++) begin
                checks++;
                if (outs[t] !== model(2, 8, sh[t])) begin
                    errors++;
                    $display("FAIL b2b_data%0d: out_data=%h expected %h", t, outs[t], model(2, 8, sh[t]));
                end
            end
            for (int t = 1; t < 3; t++) begin
                checks++;
                if (acc_cyc[t] - acc_cyc[t-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: gap=%0d expected 3", t, acc_cyc[t] - acc_cyc[t-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] sh [5];
        int sel;
        for (int n = 0; n < 1000; n++) begin
            sel = $urandom_range(0, 2);
            for (int j = 0; j < 5; j++) sh[j] = 8'($urandom);
            case (sel)
                0: run_one(0, 2, 8, sh, $urandom_range(0, 2), "rand_d2");
                1: run_one(1, 3, 4, sh, $urandom_range(0, 2), "rand_d3");
                default: run_one(3, 5, 8, sh, $urandom_range(0, 2), "rand_d5");
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/msk_unmask_serial.md
MSK_UNMASK_SERIAL -- requirements
Module: msk_unmask_serial

Interface
REQ-001 Parameter d, default 2: number of shares per bit; the block SHALL reject d < 2 at elaboration.
REQ-002 Parameter W, default 8: number of unmasked data bits.
REQ-003 clk  input  1  single clock; all state updates SHALL occur on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  W*d  sharing; share j of bit i SHALL be at index i*d+j.
REQ-006 in_valid  input  1  in_data holds a sharing to decode.
REQ-007 in_ready  output  1  block accepts a sharing this cycle.
REQ-008 out_data  output  W  recombined cleartext.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  consumer accepts out_data.

Function
REQ-011 States SHALL be IDLE, ACCUM and DONE.
REQ-012 in_ready SHALL be high exactly when state is IDLE, with no dependence on in_valid.
REQ-013 Accept SHALL occur on an edge with in_valid and in_ready both high.
- On accept, all W*d shares SHALL be captured into a share register.
- The accumulator SHALL load share 0 of every bit.
- The share counter SHALL load 1 and the state SHALL go to ACCUM.
REQ-014 Each ACCUM edge SHALL perform acc[i] ^= share[cnt] of bit i for all i, then zero that share slot and increment cnt.
- When the slot consumed was cnt = d-1, the next state SHALL be DONE.
REQ-015 At any edge, at most one share per bit SHALL be combined into the accumulator; no combinational XOR of two or more input shares is permitted.
REQ-016 out_valid SHALL be high exactly when state is DONE.
- out_data SHALL equal acc in DONE and SHALL be all-zero in every other state.
REQ-017 Latency: with the accept edge at cycle 0, out_valid SHALL rise at cycle d.
REQ-018 DONE with out_ready high: the next state SHALL be IDLE and acc, the share register and cnt SHALL clear to zero.
REQ-019 DONE with out_ready low: out_data and out_valid SHALL hold unchanged for as long as out_ready stays low.
REQ-020 Minimum period between accepts SHALL be d+1 cycles; in_valid during ACCUM or DONE SHALL be ignored.
REQ-021 cnt SHALL be ceil(log2(d+1)) bits wide and SHALL never exceed d-1.
REQ-022 out_ready in IDLE or ACCUM SHALL have no effect.

Reset
REQ-023 Asserting rst_n low SHALL immediately set the following, regardless of state, including mid-ACCUM:
- state to IDLE;
- acc, share register and cnt to 0;
- out_valid to 0, out_data to 0, in_ready to 1.
REQ-024 A sharing in flight at reset SHALL be discarded with no output.
REQ-025 The first accept after rst_n deasserts SHALL be possible on the first rising edge.

Structure
REQ-026 Package msk_unmask_pkg SHALL hold the state enumeration (IDLE, ACCUM, DONE) and the cnt-width function.
REQ-027 Sub-module msk_share_mux SHALL select share[cnt] of one bit from its d-bit slot; W instances SHALL be used.
REQ-028 There SHALL be no other sub-modules and no memories.

Verification
REQ-029 d=2, W=8, in_data encoding 0xA5 with share1=0x3C -> out_valid at cycle 2, out_data=0xA5, in_ready low in cycles 1-2.
REQ-030 d=3, W=4, shares 0x9,0x6,0xF (clear 0x0) -> out_valid at cycle 3, out_data=0x0; share register reads zero once DONE is reached.
REQ-031 d=2, out_ready held low 5 cycles after DONE -> out_data stable for all 5 cycles; IDLE on the edge after out_ready rises; second accept no earlier than cycle 3 after the first.
REQ-032 d=4, rst_n pulsed low in the 2nd ACCUM cycle -> all outputs zero and in_ready=1 asynchronously; no out_valid follows; next sharing 0x5A decodes correctly.
REQ-033 in_valid held high continuously, 3 distinct sharings, d=2 -> exactly 3 outputs in order, accepts spaced exactly 3 cycles apart with out_ready=1.
REQ-034 Random regression: 1000 random sharings and random out_ready, d in {2,3,5} -> every out_data equals the XOR of its shares; no combinational path from in_data to out_data (formal check).
